// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle RV32I control FSM that sequences one shared ALU and one memory port,
// with a ready-based memory handshake, an optional wait timeout and a sticky illegal-instruction trap.
// Define CU_BRANCH_EXT_EN to also decode blt/bge/bltu/bgeu; when it is undefined only beq/bne are legal.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic       func7_5,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       adr_src,
    output logic [1:0] mem_we,
    output logic [2:0] mem_read_mode,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [3:0] alu_control,
    output logic [3:0] state,
    output logic       illegal
);
    typedef enum logic [3:0] {
        RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, LUI, TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    state_t           cur, nxt;
    logic [CNT_W-1:0] cnt;
    logic             in_wait, timeout, taken, br_ok, ld_ok, st_ok;
    logic [3:0]       alu_op;

    assign state   = cur;
    assign in_wait = (cur == FETCH) || (cur == MEMRD) || (cur == MEMWR);
    assign timeout = (MEM_TIMEOUT != 0) && in_wait && !mem_ready && (cnt == CNT_W'(MEM_TIMEOUT - 1));
    assign ld_ok   = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010) ||
                     (func3 == 3'b100) || (func3 == 3'b101);
    assign st_ok   = func3 < 3'b011;

    // Branch condition and legality of the branch func3 encoding
    always_comb begin
        taken = 1'b0;
        br_ok = 1'b1;
        case (func3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
`ifdef CU_BRANCH_EXT_EN
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
`endif
            default: br_ok = 1'b0;
        endcase
    end

`ifndef CU_BRANCH_EXT_EN
    logic unused_flags;
    assign unused_flags = lt ^ ltu;
`endif

    // ALU operation for R-type and I-type execution; sub only exists in R-type
    always_comb begin
        case (func3)
            3'b000:  alu_op = (opcode == OP_R && func7_5) ? 4'b0001 : 4'b0000;
            3'b001:  alu_op = 4'b1000;
            3'b010:  alu_op = 4'b0101;
            3'b011:  alu_op = 4'b1010;
            3'b100:  alu_op = 4'b0110;
            3'b101:  alu_op = func7_5 ? 4'b1001 : 4'b0111;
            3'b110:  alu_op = 4'b0011;
            default: alu_op = 4'b0010;
        endcase
    end

    // Next-state selection; wait states leave on mem_ready or trap on timeout
    always_comb begin
        nxt = cur;
        case (cur)
            RST:     nxt = FETCH;
            FETCH:   nxt = mem_ready ? DECODE : (timeout ? TRAP : FETCH);
            DECODE:  nxt = (opcode == OP_LOAD || opcode == OP_STORE) ? MEMADR :
                           (opcode == OP_R)   ? EXEC_R :
                           (opcode == OP_I)   ? EXEC_I :
                           (opcode == OP_B)   ? BRANCH :
                           (opcode == OP_JAL) ? JAL :
                           (opcode == OP_LUI) ? LUI : TRAP;
            MEMADR:  nxt = (opcode == OP_LOAD) ? (ld_ok ? MEMRD : TRAP) : (st_ok ? MEMWR : TRAP);
            MEMRD:   nxt = mem_ready ? MEMWB : (timeout ? TRAP : MEMRD);
            MEMWB:   nxt = FETCH;
            MEMWR:   nxt = mem_ready ? FETCH : (timeout ? TRAP : MEMWR);
            EXEC_R:  nxt = ALUWB;
            EXEC_I:  nxt = ALUWB;
            ALUWB:   nxt = FETCH;
            BRANCH:  nxt = br_ok ? FETCH : TRAP;
            JAL:     nxt = ALUWB;
            LUI:     nxt = ALUWB;
            TRAP:    nxt = TRAP;
            default: nxt = RST;
        endcase
    end

    // State register, wait counter (counts only unanswered wait cycles) and sticky trap flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= RST;
            cnt     <= '0;
            illegal <= 1'b0;
        end else begin
            cur     <= nxt;
            cnt     <= (in_wait && !mem_ready) ? cnt + CNT_W'(1) : '0;
            illegal <= illegal | (nxt == TRAP);
        end
    end

    // Datapath controls decoded from the current state
    always_comb begin
        mem_req       = 1'b0;
        adr_src       = 1'b0;
        mem_we        = 2'b00;
        mem_read_mode = 3'b000;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        result_src    = 2'b00;
        alu_control   = 4'b0000;
        case (cur)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMRD: begin
                mem_req       = 1'b1;
                adr_src       = 1'b1;
                mem_read_mode = (func3 == 3'b000) ? 3'b001 : (func3 == 3'b001) ? 3'b010 :
                                (func3 == 3'b100) ? 3'b011 : (func3 == 3'b101) ? 3'b100 : 3'b000;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWR: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                mem_we  = (func3 == 3'b000) ? 2'b01 : (func3 == 3'b001) ? 2'b10 :
                          (func3 == 3'b010) ? 2'b11 : 2'b00;
            end
            EXEC_R: begin
                alu_src_a   = 2'b10;
                alu_control = alu_op;
            end
            EXEC_I: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_op;
            end
            ALUWB: reg_write = 1'b1;
            BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = 4'b0001;
                pc_write    = br_ok && taken;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            LUI: begin
                alu_src_b   = 2'b01;
                alu_control = 4'b0100;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: table-driven cycle-by-cycle check of the multi-cycle control unit,
// plus hand-written reset, trap, timeout and abort sequences (DUT built with MEM_TIMEOUT=4).
module tb_multicycle_control_unit;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_B = 7'b1100011;
    localparam logic [6:0] OP_J = 7'b1101111;
    localparam logic [6:0] OP_U = 7'b0110111;
    localparam logic [6:0] OP_X = 7'b1111111;
`ifdef CU_BRANCH_EXT_EN
    localparam int EXT = 1;
`else
    localparam int EXT = 0;
`endif

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] func3 = '0;
    logic       func7_5 = 1'b0, zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;
    logic       mem_req, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [1:0] mem_we, alu_src_a, alu_src_b, result_src;
    logic [2:0] mem_read_mode;
    logic [3:0] alu_control, state;
    logic [24:0] act;
    int checks = 0, errors = 0;

    multicycle_control_unit #(.MEM_TIMEOUT(4), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .func7_5(func7_5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready), .mem_req(mem_req),
        .adr_src(adr_src), .mem_we(mem_we), .mem_read_mode(mem_read_mode), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .alu_control(alu_control), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign act = {state, mem_req, adr_src, mem_we, mem_read_mode, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, result_src, alu_control, illegal};

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7, z, l, lu, rdy;
        logic [24:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Fields: state req adr we rd_mode ir_write pc_write reg_write a b result alu illegal
    function automatic logic [24:0] e(input int st, req, adr, we, rm, irw, pcw, rw, a, b, rs, alu, ill);
        return {4'(st), 1'(req), 1'(adr), 2'(we), 3'(rm), 1'(irw), 1'(pcw), 1'(rw),
                2'(a), 2'(b), 2'(rs), 4'(alu), 1'(ill)};
    endfunction

    function automatic vec_t v(input logic [6:0] op, input int f3, f7, z, l, lu, rdy, input logic [24:0] exp);
        vec_t r;
        r.op = op; r.f3 = 3'(f3); r.f7 = 1'(f7); r.z = 1'(z); r.l = 1'(l); r.lu = 1'(lu);
        r.rdy = 1'(rdy); r.exp = exp;
        return r;
    endfunction

    task automatic check(input string name, input logic [24:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input string name, input vec_t r);
        opcode = r.op; func3 = r.f3; func7_5 = r.f7; zero = r.z; lt = r.l; ltu = r.lu; mem_ready = r.rdy;
        @(negedge clk);
        check(name, r.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        #2;
        check(name, 25'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [24:0] x_rst, x_fw, x_f, x_d, x_ma, x_aw, x_t, x_rd, x_wr;
        x_rst = e(0, 0,0,0,0, 0,0,0, 0,0,0, 0, 0);
        x_fw  = e(1, 1,0,0,0, 0,0,0, 0,2,2, 0, 0);
        x_f   = e(1, 1,0,0,0, 1,1,0, 0,2,2, 0, 0);
        x_d   = e(2, 0,0,0,0, 0,0,0, 1,1,0, 0, 0);
        x_ma  = e(3, 0,0,0,0, 0,0,0, 2,1,0, 0, 0);
        x_rd  = e(4, 1,1,0,1, 0,0,0, 0,0,0, 0, 0);
        x_wr  = e(6, 1,1,2,0, 0,0,0, 0,0,0, 0, 0);
        x_aw  = e(9, 0,0,0,0, 0,0,1, 0,0,0, 0, 0);
        x_t   = e(13,0,0,0,0, 0,0,0, 0,0,0, 0, 1);
        // addi: 4 cycles
        tbl.push_back(v(OP_I, 0,0,0,0,0,1, x_rst));
        tbl.push_back(v(OP_I, 0,0,0,0,0,1, x_f));
        tbl.push_back(v(OP_I, 0,0,0,0,0,1, x_d));
        tbl.push_back(v(OP_I, 0,0,0,0,0,1, e(8, 0,0,0,0, 0,0,0, 2,1,0, 0, 0)));
        tbl.push_back(v(OP_I, 0,0,0,0,0,1, x_aw));
        // lb with three MEMRD wait cycles
        tbl.push_back(v(OP_L, 0,0,0,0,0,1, x_f));
        tbl.push_back(v(OP_L, 0,0,0,0,0,1, x_d));
        tbl.push_back(v(OP_L, 0,0,0,0,0,1, x_ma));
        tbl.push_back(v(OP_L, 0,0,0,0,0,0, x_rd));
        tbl.push_back(v(OP_L, 0,0,0,0,0,0, x_rd));
        tbl.push_back(v(OP_L, 0,0,0,0,0,0, x_rd));
        tbl.push_back(v(OP_L, 0,0,0,0,0,1, x_rd));
        tbl.push_back(v(OP_L, 0,0,0,0,0,1, e(5, 0,0,0,0, 0,0,1, 0,0,1, 0, 0)));
        // sh with one MEMWR wait cycle
        tbl.push_back(v(OP_S, 1,0,0,0,0,1, x_f));
        tbl.push_back(v(OP_S, 1,0,0,0,0,1, x_d));
        tbl.push_back(v(OP_S, 1,0,0,0,0,1, x_ma));
        tbl.push_back(v(OP_S, 1,0,0,0,0,0, x_wr));
        tbl.push_back(v(OP_S, 1,0,0,0,0,1, x_wr));
        // sub
        tbl.push_back(v(OP_R, 0,1,0,0,0,1, x_f));
        tbl.push_back(v(OP_R, 0,1,0,0,0,1, x_d));
        tbl.push_back(v(OP_R, 0,1,0,0,0,1, e(7, 0,0,0,0, 0,0,0, 2,0,0, 1, 0)));
        tbl.push_back(v(OP_R, 0,1,0,0,0,1, x_aw));
        // sltu with one fetch wait cycle
        tbl.push_back(v(OP_R, 3,0,0,0,0,0, x_fw));
        tbl.push_back(v(OP_R, 3,0,0,0,0,1, x_f));
        tbl.push_back(v(OP_R, 3,0,0,0,0,1, x_d));
        tbl.push_back(v(OP_R, 3,0,0,0,0,1, e(7, 0,0,0,0, 0,0,0, 2,0,0, 10, 0)));
        tbl.push_back(v(OP_R, 3,0,0,0,0,1, x_aw));
        // srai
        tbl.push_back(v(OP_I, 5,1,0,0,0,1, x_f));
        tbl.push_back(v(OP_I, 5,1,0,0,0,1, x_d));
        tbl.push_back(v(OP_I, 5,1,0,0,0,1, e(8, 0,0,0,0, 0,0,0, 2,1,0, 9, 0)));
        tbl.push_back(v(OP_I, 5,1,0,0,0,1, x_aw));
        // jal
        tbl.push_back(v(OP_J, 0,0,0,0,0,1, x_f));
        tbl.push_back(v(OP_J, 0,0,0,0,0,1, x_d));
        tbl.push_back(v(OP_J, 0,0,0,0,0,1, e(11,0,0,0,0, 0,1,0, 1,2,0, 0, 0)));
        tbl.push_back(v(OP_J, 0,0,0,0,0,1, x_aw));
        // lui
        tbl.push_back(v(OP_U, 0,0,0,0,0,1, x_f));
        tbl.push_back(v(OP_U, 0,0,0,0,0,1, x_d));
        tbl.push_back(v(OP_U, 0,0,0,0,0,1, e(12,0,0,0,0, 0,0,0, 0,1,0, 4, 0)));
        tbl.push_back(v(OP_U, 0,0,0,0,0,1, x_aw));
        // bne taken, beq not taken, bgeu (taken only when extended branches exist)
        tbl.push_back(v(OP_B, 1,0,0,0,0,1, x_f));
        tbl.push_back(v(OP_B, 1,0,0,0,0,1, x_d));
        tbl.push_back(v(OP_B, 1,0,0,0,0,1, e(10,0,0,0,0, 0,1,0, 2,0,0, 1, 0)));
        tbl.push_back(v(OP_B, 0,0,0,0,0,1, x_f));
        tbl.push_back(v(OP_B, 0,0,0,0,0,1, x_d));
        tbl.push_back(v(OP_B, 0,0,0,0,0,1, e(10,0,0,0,0, 0,0,0, 2,0,0, 1, 0)));
        tbl.push_back(v(OP_B, 7,0,0,0,0,1, x_f));
        tbl.push_back(v(OP_B, 7,0,0,0,0,1, x_d));
        tbl.push_back(v(OP_B, 7,0,0,0,0,1, e(10,0,0,0,0, 0,EXT,0, 2,0,0, 1, 0)));
        tbl.push_back(v(OP_I, 0,0,0,0,0,1, EXT != 0 ? x_f : x_t));

        do_reset("reset_start");
        foreach (tbl[i]) step($sformatf("row%0d", i), tbl[i]);

        // Illegal opcode traps from DECODE and stays trapped whatever mem_ready does
        do_reset("reset_illop");
        step("illop_rst", v(OP_X, 0,0,0,0,0,1, x_rst));
        step("illop_fetch", v(OP_X, 0,0,0,0,0,1, x_f));
        step("illop_decode", v(OP_X, 0,0,0,0,0,1, x_d));
        step("illop_trap0", v(OP_X, 0,0,0,0,0,1, x_t));
        step("illop_trap1", v(OP_I, 0,0,0,0,0,0, x_t));
        step("illop_trap2", v(OP_I, 0,0,0,0,0,1, x_t));

        // Illegal load width (func3 011) traps from MEMADR; reset clears the sticky flag
        do_reset("reset_ldw");
        step("ldw_rst", v(OP_L, 3,0,0,0,0,1, x_rst));
        step("ldw_fetch", v(OP_L, 3,0,0,0,0,1, x_f));
        step("ldw_decode", v(OP_L, 3,0,0,0,0,1, x_d));
        step("ldw_memadr", v(OP_L, 3,0,0,0,0,1, x_ma));
        step("ldw_trap", v(OP_L, 3,0,0,0,0,1, x_t));

        // blt with lt=1
        do_reset("reset_blt");
        step("blt_rst", v(OP_B, 4,0,1,1,0,1, x_rst));
        step("blt_fetch", v(OP_B, 4,0,1,1,0,1, x_f));
        step("blt_decode", v(OP_B, 4,0,1,1,0,1, x_d));
        step("blt_branch", v(OP_B, 4,0,1,1,0,1, e(10,0,0,0,0, 0,EXT,0, 2,0,0, 1, 0)));
        step("blt_after", v(OP_B, 4,0,1,1,0,1, EXT != 0 ? x_f : x_t));

        // Fetch timeout after four unanswered wait cycles
        do_reset("reset_tmo");
        step("tmo_rst", v(OP_I, 0,0,0,0,0,0, x_rst));
        for (int k = 0; k < 4; k++) step($sformatf("tmo_wait%0d", k), v(OP_I, 0,0,0,0,0,0, x_fw));
        step("tmo_trap0", v(OP_I, 0,0,0,0,0,1, x_t));
        step("tmo_trap1", v(OP_I, 0,0,0,0,0,1, x_t));

        // Reset asserted in the middle of a store aborts the write at once
        do_reset("reset_abort");
        step("abort_rst", v(OP_S, 2,0,0,0,0,1, x_rst));
        step("abort_fetch", v(OP_S, 2,0,0,0,0,1, x_f));
        step("abort_decode", v(OP_S, 2,0,0,0,0,1, x_d));
        step("abort_memadr", v(OP_S, 2,0,0,0,0,1, x_ma));
        mem_ready = 1'b1;
        @(negedge clk);
        check("abort_memwr", e(6, 1,1,3,0, 0,0,0, 0,0,0, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_async", x_rst);
        @(posedge clk);
        #1;
        check("abort_held", x_rst);
        rst_n = 1'b1;
        step("abort_restart_rst", v(OP_S, 2,0,0,0,0,1, x_rst));
        step("abort_restart_fetch", v(OP_S, 2,0,0,0,0,1, x_f));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
